// File: rtl/apu_envelope_length_pkg.sv
// Shared widths, register-0 field layout and the length-counter load table
// for the pulse/noise envelope and length block.
package apu_pkg;

    localparam int DECAY_W = 4;
    localparam int LEN_W   = 8;

    // Index 0 is the leftmost entry, so LENGTH_TABLE[data_in[7:3]] reads naturally.
    localparam logic [0:31][LEN_W-1:0] LENGTH_TABLE = {
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    typedef struct packed {
        logic               halt_loop;
        logic               const_vol;
        logic [DECAY_W-1:0] vparam;
    } reg0_t;

endpackage

// File: rtl/apu_envelope_length_if.sv
// CPU write bus and mixer-facing outputs of one envelope/length channel.
interface apu_envelope_length_if;
    import apu_pkg::*;

    logic               chan_enable;
    logic               reg0_we;
    logic               reg3_we;
    logic [7:0]         data_in;
    logic [DECAY_W-1:0] volume;
    logic               length_active;

    modport master (
        output chan_enable, reg0_we, reg3_we, data_in,
        input  volume, length_active
    );

    modport slave (
        input  chan_enable, reg0_we, reg3_we, data_in,
        output volume, length_active
    );

endinterface

// File: rtl/apu_envelope_length_toggle_edge.sv
// Turns a toggle-encoded frame clock into a one-cycle event pulse; the history
// flop reloads on reset so a level held across reset never looks like a toggle.
module apu_toggle_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic tog_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        prev_q <= tog_i;
    end

    assign pulse_o = rst_n_i & (tog_i ^ prev_q);

endmodule

// File: rtl/apu_envelope_length.sv
// Envelope generator and length counter for one pulse/noise channel, clocked by
// the frame sequencer's quarter/half toggles.
module apu_envelope_length
    import apu_pkg::*;
(
    input  logic                  cpu_clk,
    input  logic                  reset_n,
    input  logic                  quarter_clock,
    input  logic                  half_clock,
    apu_envelope_length_if.slave  bus
);

    logic q_evt;
    logic h_evt;

    reg0_t              reg0_q,    reg0_d;
    logic               start_q,   start_d;
    logic [DECAY_W-1:0] decay_q,   decay_d;
    logic [DECAY_W-1:0] divider_q, divider_d;
    logic [LEN_W-1:0]   length_q,  length_d;

    apu_toggle_edge u_quarter (
        .clk_i   (cpu_clk),
        .rst_n_i (reset_n),
        .tog_i   (quarter_clock),
        .pulse_o (q_evt)
    );

    apu_toggle_edge u_half (
        .clk_i   (cpu_clk),
        .rst_n_i (reset_n),
        .tog_i   (half_clock),
        .pulse_o (h_evt)
    );

    always_comb begin
        reg0_d    = reg0_q;
        start_d   = start_q;
        decay_d   = decay_q;
        divider_d = divider_q;
        length_d  = length_q;

        // Events see the reg0 fields and start flag as they were before this cycle's writes.
        if (q_evt) begin
            if (start_q) begin
                start_d   = 1'b0;
                decay_d   = '1;
                divider_d = reg0_q.vparam;
            end else if (divider_q == '0) begin
                divider_d = reg0_q.vparam;
                if (decay_q != '0) begin
                    decay_d = decay_q - 1'b1;
                end else if (reg0_q.halt_loop) begin
                    decay_d = '1;
                end
            end else begin
                divider_d = divider_q - 1'b1;
            end
        end

        if (h_evt && length_q != '0 && !reg0_q.halt_loop) begin
            length_d = length_q - 1'b1;
        end

        if (bus.reg0_we) begin
            reg0_d = reg0_t'(bus.data_in[5:0]);
        end

        if (bus.reg3_we) begin
            start_d  = 1'b1;
            length_d = LENGTH_TABLE[bus.data_in[7:3]];
        end

        if (!bus.chan_enable) begin
            length_d = '0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            reg0_q    <= '0;
            start_q   <= 1'b0;
            decay_q   <= '0;
            divider_q <= '0;
            length_q  <= '0;
        end else begin
            reg0_q    <= reg0_d;
            start_q   <= start_d;
            decay_q   <= decay_d;
            divider_q <= divider_d;
            length_q  <= length_d;
        end
    end

    assign bus.volume        = reg0_q.const_vol ? reg0_q.vparam : decay_q;
    assign bus.length_active = (length_q != '0);

endmodule

// File: tb/tb_apu_envelope_length.sv
// Directed bench for apu_envelope_length: reset, length counting, halt, envelope
// decay/loop, constant volume, enable and same-cycle write/event ordering.
module tb_apu_envelope_length;

    logic cpu_clk = 1'b0;
    logic reset_n = 1'b0;
    logic quarter_clock = 1'b0;
    logic half_clock = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    apu_envelope_length_if bus_if ();

    apu_envelope_length dut (
        .cpu_clk       (cpu_clk),
        .reset_n       (reset_n),
        .quarter_clock (quarter_clock),
        .half_clock    (half_clock),
        .bus           (bus_if)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic tog_q(input int n);
        for (int i = 0; i < n; i++) begin
            quarter_clock = ~quarter_clock;
            tick();
        end
    endtask

    task automatic tog_h(input int n);
        for (int i = 0; i < n; i++) begin
            half_clock = ~half_clock;
            tick();
        end
    endtask

    task automatic write0(input logic [7:0] d);
        bus_if.data_in = d;
        bus_if.reg0_we = 1'b1;
        tick();
        bus_if.reg0_we = 1'b0;
    endtask

    task automatic write3(input logic [7:0] d);
        bus_if.data_in = d;
        bus_if.reg3_we = 1'b1;
        tick();
        bus_if.reg3_we = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        reset_n = 1'b0;
        quarter_clock = 1'b1;
        half_clock = 1'b1;
        tick(); tick(); tick();
        n_total++;
        if (bus_if.volume !== 4'd0 || bus_if.length_active !== 1'b0)
            $display("FAIL reset_hold vol=%0d la=%0b want vol=0 la=0", bus_if.volume, bus_if.length_active);
        else n_pass++;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.volume !== 4'd0 || bus_if.length_active !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL reset_release_quiet saw nonzero vol/la in 100 cycles, want vol=0 la=0");
        else n_pass++;
    endtask

    task automatic test_length_count();
        bus_if.chan_enable = 1'b1;
        write3(8'h08);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL len254_load la=%0b want 1", bus_if.length_active);
        else n_pass++;
        tog_h(253);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL len254_after253 la=%0b want 1", bus_if.length_active);
        else n_pass++;
        tog_h(1);
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL len254_after254 la=%0b want 0", bus_if.length_active);
        else n_pass++;
        tog_h(5);
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL len_no_wrap la=%0b want 0", bus_if.length_active);
        else n_pass++;
    endtask

    task automatic test_halt();
        write0(8'h20);
        write3(8'h00);
        tog_h(20);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL halt_hold la=%0b want 1", bus_if.length_active);
        else n_pass++;
        write0(8'h00);
        tog_h(9);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL halt_len10_after9 la=%0b want 1", bus_if.length_active);
        else n_pass++;
        tog_h(1);
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL halt_len10_after10 la=%0b want 0", bus_if.length_active);
        else n_pass++;
    endtask

    task automatic test_envelope();
        write0(8'h03);
        write3(8'h00);
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL env_start vol=%0d want 15", bus_if.volume);
        else n_pass++;
        tog_q(3);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL env_div3 vol=%0d want 15", bus_if.volume);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd14) $display("FAIL env_div4 vol=%0d want 14", bus_if.volume);
        else n_pass++;
        tog_q(55);
        n_total++;
        if (bus_if.volume !== 4'd1) $display("FAIL env_after59 vol=%0d want 1", bus_if.volume);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd0) $display("FAIL env_after60 vol=%0d want 0", bus_if.volume);
        else n_pass++;
        tog_q(8);
        n_total++;
        if (bus_if.volume !== 4'd0) $display("FAIL env_hold0 vol=%0d want 0", bus_if.volume);
        else n_pass++;

        write0(8'h23);
        write3(8'h00);
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL loop_start vol=%0d want 15", bus_if.volume);
        else n_pass++;
        tog_q(63);
        n_total++;
        if (bus_if.volume !== 4'd0) $display("FAIL loop_at0 vol=%0d want 0", bus_if.volume);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL loop_wrap vol=%0d want 15", bus_if.volume);
        else n_pass++;
    endtask

    task automatic test_const_volume();
        write0(8'h17);
        n_total++;
        if (bus_if.volume !== 4'd7) $display("FAIL const_vol vol=%0d want 7", bus_if.volume);
        else n_pass++;
        tog_q(10);
        n_total++;
        if (bus_if.volume !== 4'd7) $display("FAIL const_vol_toggled vol=%0d want 7", bus_if.volume);
        else n_pass++;
    endtask

    task automatic test_enable();
        write0(8'h00);
        bus_if.chan_enable = 1'b1;
        write3(8'hB0);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL en_load96 la=%0b want 1", bus_if.length_active);
        else n_pass++;
        bus_if.chan_enable = 1'b0;
        tick();
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL en_drop la=%0b want 0", bus_if.length_active);
        else n_pass++;
        write3(8'h08);
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL en_write_disabled la=%0b want 0", bus_if.length_active);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL en_disabled_start vol=%0d want 15", bus_if.volume);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd14) $display("FAIL en_disabled_decay vol=%0d want 14", bus_if.volume);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus_if.chan_enable = 1'b1;
        write0(8'h00);
        bus_if.data_in = 8'h08;
        bus_if.reg3_we = 1'b1;
        half_clock = ~half_clock;
        tick();
        bus_if.reg3_we = 1'b0;
        tog_h(253);
        n_total++;
        if (bus_if.length_active !== 1'b1) $display("FAIL simul_h_load_253 la=%0b want 1", bus_if.length_active);
        else n_pass++;
        tog_h(1);
        n_total++;
        if (bus_if.length_active !== 1'b0) $display("FAIL simul_h_load_254 la=%0b want 0", bus_if.length_active);
        else n_pass++;

        write3(8'h00);
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL simul_q_pre vol=%0d want 15", bus_if.volume);
        else n_pass++;
        bus_if.data_in = 8'h00;
        bus_if.reg3_we = 1'b1;
        quarter_clock = ~quarter_clock;
        tick();
        bus_if.reg3_we = 1'b0;
        n_total++;
        if (bus_if.volume !== 4'd14) $display("FAIL simul_q_oldstart vol=%0d want 14", bus_if.volume);
        else n_pass++;
        tog_q(1);
        n_total++;
        if (bus_if.volume !== 4'd15) $display("FAIL simul_q_startkept vol=%0d want 15", bus_if.volume);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        write3(8'h08);
        reset_n = 1'b0;
        tick();
        quarter_clock = ~quarter_clock;
        half_clock = ~half_clock;
        tick();
        reset_n = 1'b1;
        tick();
        n_total++;
        if (bus_if.volume !== 4'd0 || bus_if.length_active !== 1'b0)
            $display("FAIL reset_mid vol=%0d la=%0b want vol=0 la=0", bus_if.volume, bus_if.length_active);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (bus_if.volume !== 4'd0 || bus_if.length_active !== 1'b0)
            $display("FAIL reset_mid_absorb vol=%0d la=%0b want vol=0 la=0", bus_if.volume, bus_if.length_active);
        else n_pass++;
    endtask

    initial begin
        bus_if.chan_enable = 1'b0;
        bus_if.reg0_we = 1'b0;
        bus_if.reg3_we = 1'b0;
        bus_if.data_in = 8'h00;
        test_reset();
        test_length_count();
        test_halt();
        test_envelope();
        test_const_volume();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
